// File: rtl/sprite_bounce_engine.sv
// Bouncing-sprite compositor: moves a rectangular sprite once per frame, reflects it off
// the screen edges, and overlays its ROM pixels on a flat background with colour keying.
module sprite_bounce_engine #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned SPR_W     = 256,
  parameter int unsigned SPR_H     = 192,
  parameter logic [23:0] BG_COLOR  = 24'h000000,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  parameter bit          KEY_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        run,
  input  logic [3:0]  step,
  output logic [9:0]  spr_x,
  output logic [9:0]  spr_y,
  input  logic [23:0] sprite_rgb,
  output logic [23:0] vga_data,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic [15:0] bounce_cnt,
  output logic        frame_tick,
  output logic        corner_hit
);

  localparam logic [10:0] XLim   = 11'(H_RES - SPR_W);
  localparam logic [10:0] YLim   = 11'(V_RES - SPR_H);
  localparam logic [10:0] SprW11 = 11'(SPR_W);
  localparam logic [10:0] SprH11 = 11'(SPR_H);
  localparam logic [9:0]  HLast  = 10'(H_RES - 1);
  localparam logic [9:0]  VLast  = 10'(V_RES - 1);

  logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [15:0] cnt_q, cnt_d;
  logic        corner_q, corner_d;
  logic        hit, hit_d, valid_d;
  logic        update, bounce_x, bounce_y;
  logic [11:0] nxt_x, nxt_y;

  // Returns {bounce, dir, pos} for one axis; step=0 never moves or bounces.
  function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic dir,
                                            input logic [3:0] stp, input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + {7'd0, stp};
    axis_next = {1'b0, dir, pos};
    if (stp != 4'd0) begin
      if (!dir) begin
        if (sum >= lim) axis_next = {1'b1, 1'b1, lim[9:0]};
        else            axis_next = {1'b0, 1'b0, sum[9:0]};
      end else begin
        if (pos <= {6'd0, stp}) axis_next = {1'b1, 1'b0, 10'd0};
        else                    axis_next = {1'b0, 1'b1, pos - {6'd0, stp}};
      end
    end
  endfunction

  assign frame_tick = valid && (h_addr == HLast) && (v_addr == VLast);
  assign update     = frame_tick && run;

  always_comb begin
    nxt_x    = axis_next(pos_x_q, dir_x_q, step, XLim);
    nxt_y    = axis_next(pos_y_q, dir_y_q, step, YLim);
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_x = 1'b0;
    bounce_y = 1'b0;
    if (update) begin
      {bounce_x, dir_x_d, pos_x_d} = nxt_x;
      {bounce_y, dir_y_d, pos_y_d} = nxt_y;
    end
    cnt_d    = cnt_q;
    // A corner counts once, so OR the two axis events before incrementing.
    if ((bounce_x || bounce_y) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    corner_d = bounce_x && bounce_y;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      cnt_q    <= '0;
      corner_q <= 1'b0;
      hit_d    <= 1'b0;
      valid_d  <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      cnt_q    <= cnt_d;
      corner_q <= corner_d;
      hit_d    <= hit;
      valid_d  <= valid;
    end
  end

  always_comb begin
    hit = ({1'b0, h_addr} >= {1'b0, pos_x_q}) && ({1'b0, h_addr} < ({1'b0, pos_x_q} + SprW11))
       && ({1'b0, v_addr} >= {1'b0, pos_y_q}) && ({1'b0, v_addr} < ({1'b0, pos_y_q} + SprH11));
    spr_x = '0;
    spr_y = '0;
    if (hit) begin
      spr_x = h_addr - pos_x_q;
      spr_y = v_addr - pos_y_q;
    end
  end

  always_comb begin
    vga_data = BG_COLOR;
    if (valid_d && hit_d && !(KEY_EN && (sprite_rgb == KEY_COLOR))) vga_data = sprite_rgb;
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign bounce_cnt = cnt_q;
  assign corner_hit = corner_q;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Bench for sprite_bounce_engine: default-size motion and compositing, a square 64x64 on
// 128x128 instance for corner bounces, and a zero-range instance for counter saturation.
module tb_sprite_bounce_engine;

  localparam logic [23:0] Bg  = 24'h000000;
  localparam logic [23:0] Key = 24'hFF00FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic [9:0]  h, v, sx, sy, px, py;
  logic        vld, run, dx, dy, ft, ch;
  logic [3:0]  stp;
  logic [23:0] rgb, vga;
  logic [15:0] cnt;

  // Instance B: 64x64 on 128x128
  logic [9:0]  b_h, b_v, b_sx, b_sy, b_px, b_py;
  logic        b_vld, b_run, b_dx, b_dy, b_ft, b_ch;
  logic [3:0]  b_stp;
  logic [23:0] b_vga;
  logic [15:0] b_cnt;

  // Instance C: sprite fills the screen, so every moving frame is a corner bounce
  logic [9:0]  c_h, c_v, c_sx, c_sy, c_px, c_py;
  logic        c_vld, c_run, c_dx, c_dy, c_ft, c_ch;
  logic [3:0]  c_stp;
  logic [23:0] c_vga;
  logic [15:0] c_cnt;

  sprite_bounce_engine dut_a (
    .clk(clk), .rst(rst), .h_addr(h), .v_addr(v), .valid(vld), .run(run), .step(stp),
    .spr_x(sx), .spr_y(sy), .sprite_rgb(rgb), .vga_data(vga), .pos_x(px), .pos_y(py),
    .dir_x(dx), .dir_y(dy), .bounce_cnt(cnt), .frame_tick(ft), .corner_hit(ch)
  );

  sprite_bounce_engine #(.H_RES(128), .V_RES(128), .SPR_W(64), .SPR_H(64)) dut_b (
    .clk(clk), .rst(rst), .h_addr(b_h), .v_addr(b_v), .valid(b_vld), .run(b_run),
    .step(b_stp), .spr_x(b_sx), .spr_y(b_sy), .sprite_rgb(24'h0), .vga_data(b_vga),
    .pos_x(b_px), .pos_y(b_py), .dir_x(b_dx), .dir_y(b_dy), .bounce_cnt(b_cnt),
    .frame_tick(b_ft), .corner_hit(b_ch)
  );

  sprite_bounce_engine #(.H_RES(16), .V_RES(16), .SPR_W(16), .SPR_H(16)) dut_c (
    .clk(clk), .rst(rst), .h_addr(c_h), .v_addr(c_v), .valid(c_vld), .run(c_run),
    .step(c_stp), .spr_x(c_sx), .spr_y(c_sy), .sprite_rgb(24'h0), .vga_data(c_vga),
    .pos_x(c_px), .pos_y(c_py), .dir_x(c_dx), .dir_y(c_dy), .bounce_cnt(c_cnt),
    .frame_tick(c_ft), .corner_hit(c_ch)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int ex, input int ey, input bit edx,
                       input bit edy, input int ec);
    chk({tag, " pos_x"}, 32'(px), 32'(ex));
    chk({tag, " pos_y"}, 32'(py), 32'(ey));
    chk({tag, " dir_x"}, 32'(dx), 32'(edx));
    chk({tag, " dir_y"}, 32'(dy), 32'(edy));
    chk({tag, " bounce_cnt"}, 32'(cnt), 32'(ec));
  endtask

  typedef struct {
    logic        vld;
    logic [9:0]  h, v;
    logic [23:0] rgb, exp_vga;
    logic [9:0]  exp_sx, exp_sy;
  } pix_vec_t;

  pix_vec_t    vecs[9];
  logic [23:0] exp_q[$];

  initial begin
    // Sprite at (10,10), 256x192: covers h 10..265, v 10..201
    vecs[0] = '{1'b1, 10'd10,  10'd10,  24'h123456, 24'h123456, 10'd0,   10'd0};
    vecs[1] = '{1'b1, 10'd9,   10'd10,  24'h123456, Bg,         10'd0,   10'd0};
    vecs[2] = '{1'b1, 10'd10,  10'd10,  Key,        Bg,         10'd0,   10'd0};
    vecs[3] = '{1'b1, 10'd265, 10'd201, 24'hABCDEF, 24'hABCDEF, 10'd255, 10'd191};
    vecs[4] = '{1'b1, 10'd266, 10'd100, 24'hABCDEF, Bg,         10'd0,   10'd0};
    vecs[5] = '{1'b1, 10'd100, 10'd202, 24'h777777, Bg,         10'd0,   10'd0};
    vecs[6] = '{1'b0, 10'd50,  10'd50,  24'h111111, Bg,         10'd40,  10'd40};
    vecs[7] = '{1'b1, 10'd50,  10'd9,   24'h222222, Bg,         10'd0,   10'd0};
    vecs[8] = '{1'b1, 10'd639, 10'd479, 24'h333333, Bg,         10'd0,   10'd0};

    rst = 1'b0;
    vld = 1'b1; h = 10'd639; v = 10'd479; run = 1'b1; stp = 4'd1; rgb = 24'h123456;
    b_vld = 1'b0; b_h = 10'd0; b_v = 10'd0; b_run = 1'b0; b_stp = 4'd0;
    c_vld = 1'b0; c_h = 10'd0; c_v = 10'd0; c_run = 1'b0; c_stp = 4'd0;
    #1;
    chk_a("reset", 0, 0, 0, 0, 0);
    chk("reset corner_hit", 32'(ch), 32'd0);
    chk("reset vga_data", 32'(vga), 32'(Bg));
    chk("frame_tick at last pixel", 32'(ft), 32'd1);
    repeat (2) cyc();
    chk_a("held in reset", 0, 0, 0, 0, 0);
    h = 10'd638; #1;
    chk("frame_tick off last pixel", 32'(ft), 32'd0);
    h = 10'd639;

    // Default sprite, step 1, one tick per cycle
    rst = 1'b1;
    repeat (288) cyc();
    chk_a("frame 288", 288, 288, 0, 1, 1);
    repeat (96) cyc();
    chk_a("frame 384", 384, 192, 1, 1, 2);

    run = 1'b0;
    repeat (10) cyc();
    chk_a("run=0 frozen", 384, 192, 1, 1, 2);

    // Mid-line reset while the sprite is being shown
    h = 10'd400; v = 10'd200; rgb = 24'h5A5A5A;
    cyc();
    chk("pre-reset vga_data", 32'(vga), 32'h5A5A5A);
    rst = 1'b0; #1;
    chk_a("mid-line reset", 0, 0, 0, 0, 0);
    chk("mid-line reset vga_data", 32'(vga), 32'(Bg));
    cyc();
    rst = 1'b1;

    // Approach the right edge with step 10, then overshoot with step 15
    h = 10'd639; v = 10'd479; run = 1'b1; stp = 4'd10;
    repeat (38) cyc();
    chk_a("pos 380", 380, 198, 0, 1, 1);
    stp = 4'd15;
    cyc();
    chk_a("step15 bounce", 384, 183, 1, 1, 2);
    cyc();
    chk("after bounce pos_x", 32'(px), 32'd369);

    // Park the sprite at (10,10) and run the pixel table
    rst = 1'b0; #1; rst = 1'b1;
    stp = 4'd10;
    cyc();
    run = 1'b0;
    chk("parked pos_x", 32'(px), 32'd10);
    chk("parked pos_y", 32'(py), 32'd10);
    for (int i = 0; i < 9; i++) begin
      vld = vecs[i].vld; h = vecs[i].h; v = vecs[i].v;
      rgb = (i > 0) ? vecs[i-1].rgb : 24'h0;
      #1;
      chk($sformatf("vec%0d spr_x", i), 32'(sx), 32'(vecs[i].exp_sx));
      chk($sformatf("vec%0d spr_y", i), 32'(sy), 32'(vecs[i].exp_sy));
      if (exp_q.size() > 0) chk($sformatf("vec%0d vga_data", i - 1), 32'(vga),
                                32'(exp_q.pop_front()));
      exp_q.push_back(vecs[i].exp_vga);
      cyc();
    end
    vld = 1'b0; rgb = vecs[8].rgb; #1;
    chk("vec8 vga_data", 32'(vga), 32'(exp_q.pop_front()));
    chk("pixel ticks did not move", 32'(px), 32'd10);

    // Square sprite: both axes bounce together every 64 frames
    b_vld = 1'b1; b_h = 10'd127; b_v = 10'd127; b_run = 1'b1; b_stp = 4'd1;
    repeat (63) cyc();
    chk("B before corner", 32'(b_ch), 32'd0);
    cyc();
    chk("B corner1 pulse", 32'(b_ch), 32'd1);
    chk("B corner1 cnt", 32'(b_cnt), 32'd1);
    chk("B corner1 pos", 32'({b_px, b_py, b_dx, b_dy}), 32'({10'd64, 10'd64, 2'b11}));
    cyc();
    chk("B pulse width", 32'(b_ch), 32'd0);
    repeat (62) cyc();
    chk("B before corner2", 32'(b_ch), 32'd0);
    cyc();
    chk("B corner2 pulse", 32'(b_ch), 32'd1);
    chk("B corner2 cnt", 32'(b_cnt), 32'd2);
    chk("B corner2 pos", 32'({b_px, b_py, b_dx, b_dy}), 32'({10'd0, 10'd0, 2'b00}));

    // Zero-range instance: step 0 at the edge must not bounce
    c_vld = 1'b1; c_h = 10'd15; c_v = 10'd15; c_run = 1'b1; c_stp = 4'd0;
    repeat (5) cyc();
    chk("C step0 cnt", 32'(c_cnt), 32'd0);
    chk("C step0 dir", 32'({c_dx, c_dy}), 32'd0);
    c_stp = 4'd1;
    repeat (65534) cyc();
    chk("C cnt FFFE", 32'(c_cnt), 32'hFFFE);
    chk("C corner each tick", 32'(c_ch), 32'd1);
    cyc();
    chk("C cnt FFFF", 32'(c_cnt), 32'hFFFF);
    repeat (3) cyc();
    chk("C cnt saturated", 32'(c_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_bounce_engine.md
SPRITE_BOUNCE_ENGINE -- requirements
Module: sprite_bounce_engine

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter SPR_W, default 256, meaning sprite width in pixels; SPR_W <= H_RES.
REQ-004 SHALL have parameter SPR_H, default 192, meaning sprite height in lines; SPR_H <= V_RES.
REQ-005 SHALL have parameter BG_COLOR, default 24'h000000, meaning the colour outside the sprite and for transparent pixels.
REQ-006 SHALL have parameter KEY_COLOR, default 24'hFF00FF, meaning the transparent sprite colour.
REQ-007 SHALL have parameter KEY_EN, default 1, meaning transparency is enabled when 1.
REQ-008 SHALL have port clk, input, 1 bit, meaning the pixel clock; single clock domain.
REQ-009 SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset (rst=0 resets).
REQ-010 SHALL have ports h_addr and v_addr, input, 10 bits each, meaning the current pixel coordinate from the VGA controller.
REQ-011 SHALL have port valid, input, 1 bit, meaning the current pixel is in the visible area.
REQ-012 SHALL have port run, input, 1 bit, meaning motion is enabled; 0 freezes the position.
REQ-013 SHALL have port step, input, 4 bits, meaning pixels moved per frame on each axis.
REQ-014 SHALL have ports spr_x and spr_y, output, 10 bits each, meaning the sprite-relative ROM address (synchronous ROM, 1-cycle read).
REQ-015 SHALL have port sprite_rgb, input, 24 bits, meaning ROM data returned one cycle after spr_x/spr_y.
REQ-016 SHALL have port vga_data, output, 24 bits, meaning the composed pixel colour.
REQ-017 SHALL have ports pos_x and pos_y (10 bits), dir_x and dir_y (1 bit), bounce_cnt (16 bits), frame_tick (1 bit) and corner_hit (1 bit), all outputs, meaning state observation.

Function
REQ-018 frame_tick SHALL be a combinational 1-cycle pulse, asserted when valid=1, h_addr=H_RES-1 and v_addr=V_RES-1.
REQ-019 Position and direction SHALL update only in the cycle where frame_tick=1 and run=1; otherwise they SHALL hold.
REQ-020 X moving right (dir_x=0): if pos_x+step >= H_RES-SPR_W, then pos_x <= H_RES-SPR_W and dir_x <= 1 (bounce); else pos_x <= pos_x+step.
REQ-021 X moving left (dir_x=1): if pos_x <= step, then pos_x <= 0 and dir_x <= 0 (bounce); else pos_x <= pos_x-step.
REQ-022 The Y axis SHALL follow REQ-020/021 with V_RES, SPR_H, pos_y and dir_y (dir_y=0 means down); Y arithmetic SHALL use 11-bit intermediates so no wrap occurs.
REQ-023 step=0 SHALL cause no movement and no bounce, even at an edge.
REQ-024 Any single-axis bounce SHALL increment bounce_cnt by 1.
REQ-025 A simultaneous X and Y bounce SHALL increment bounce_cnt by 1 only, and SHALL pulse corner_hit for 1 cycle after the update.
REQ-026 bounce_cnt SHALL saturate at 16'hFFFF.
REQ-027 hit SHALL be defined as pos_x <= h_addr < pos_x+SPR_W and pos_y <= v_addr < pos_y+SPR_H, using an unsigned 11-bit compare.
REQ-028 spr_x and spr_y SHALL be the combinational values h_addr-pos_x and v_addr-pos_y when hit=1; when hit=0 they SHALL be 0.
REQ-029 hit and valid SHALL be registered one stage (hit_d, valid_d) to align with sprite_rgb.
REQ-030 vga_data SHALL equal sprite_rgb when valid_d=1, hit_d=1 and not (KEY_EN=1 and sprite_rgb=KEY_COLOR); otherwise it SHALL equal BG_COLOR.
REQ-031 Fixed pixel latency SHALL be 1 cycle from h_addr/v_addr to vga_data.
REQ-032 A position update in the frame_tick cycle SHALL take effect from the first pixel of the next frame; the pixel in the frame_tick cycle SHALL use the old position.

Reset
REQ-033 While rst=0, the block SHALL hold pos_x=0, pos_y=0, dir_x=0, dir_y=0, bounce_cnt=0, corner_hit=0, hit_d=0 and valid_d=0; vga_data SHALL therefore be BG_COLOR.
REQ-034 Reset asserted mid-frame SHALL take effect immediately; normal operation SHALL resume on the first clk edge after rst=1, with no partial update.

Verification
REQ-035 Defaults, run=1, step=1, 384 frames -> pos_x reaches 384 with dir_x=1 at frame 384; pos_y reaches 288 with dir_y=1 at frame 288; bounce_cnt=2.
REQ-036 step=15, pos_x=380 moving right, one frame -> pos_x=384, dir_x=1, bounce_cnt+1; the next frame -> pos_x=369.
REQ-037 Square 64x64 sprite on a 128x128 screen, step=1, run=1 -> bounces coincide every 64 frames; corner_hit pulses and bounce_cnt increments by 1 per corner.
REQ-038 pos=(10,20), h=10/v=20 with ROM=24'h123456 -> vga_data=24'h123456 one cycle later and spr_x=spr_y=0; h=9 -> BG_COLOR; ROM=KEY_COLOR -> BG_COLOR.
REQ-039 run=0 across 10 frame_ticks -> position and bounce_cnt unchanged; rst pulsed low mid-line -> all state zero immediately, vga_data=BG_COLOR.
REQ-040 bounce_cnt preloaded to 16'hFFFE, two bounces -> bounce_cnt=16'hFFFF and holds there.
